ram_responder: RTL and testbench

- Memory-side endpoint of the decoder FSM's RAM port: 16x4 synchronous RAM driven by ram_addr / ram_data_in / ram_crtl, returns ram_data_out.
- Adds a post-reset clear sequencer, a ready indication and a one-cycle read-valid strobe, so the FSM's FETCH/STORE states have a defined timing contract.
- Sits beside the ALU in the 4-bit CPU top level; the decoder FSM is its only initiator.

---
 rtl/ram_responder.sv | 123 ++++++++++++
 tb/tb_ram_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: 16x4 synchronous RAM endpoint for the decoder FSM.
// After reset it zeroes every word (CLEAR_ON_RESET=1) and then raises ram_ready.
// Reads return registered data with a one-cycle ram_valid strobe.
// Optional macro RAM_PARITY_EN adds a stored even-parity bit per word,
// a par_inject input and a ram_par_err output.
module ram_responder #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data_in,
  input  logic [1:0]        ram_crtl,
`ifdef RAM_PARITY_EN
  input  logic              par_inject,
  output logic              ram_par_err,
`endif
  output logic [DATA_W-1:0] ram_data_out,
  output logic              ram_valid,
  output logic              ram_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t            state, next_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              cs, rw;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem [DEPTH];

  assign cs = ram_crtl[1];
  assign rw = ram_crtl[0];

  // State register and clear-address counter; reset mid-clear restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // Next state and write/read port steering; clear owns the write port.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_addr    = ram_addr;
    wr_data    = ram_data_in;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
        if (clr_cnt == LAST_ADDR) next_state = READY;
      end
      READY: begin
        // ram_ready gates requests so the first READY edge after a
        // skipped clear still ignores the bus.
        if (ram_ready && cs) begin
          wr_en = rw;
          rd_en = !rw;
        end
      end
      default: next_state = RST_STATE;
    endcase
  end

  // ram_ready rises on the same edge that enters READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_ready <= 1'b0;
    else     ram_ready <= (next_state == READY);
  end

  // Storage array; not reset, the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read data and its valid strobe; data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_data_out <= '0;
      ram_valid    <= 1'b0;
    end else begin
      ram_valid <= rd_en;
      if (rd_en) ram_data_out <= mem[ram_addr];
    end
  end

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_par;

  // Even parity of the write data, optionally corrupted; clear stores 0.
  always_comb begin
    wr_par = 1'b0;
    if (state != CLEAR) wr_par = (^ram_data_in) ^ par_inject;
  end

  // Parity storage alongside the data words.
  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_addr] <= wr_par;
  end

  // Parity check pulse aligned with ram_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_par_err <= 1'b0;
    else     ram_par_err <= rd_en && ((^mem[ram_addr]) != par_mem[ram_addr]);
  end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder.
module tb_ram_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ram_addr = '0;
  logic [3:0] ram_data_in = '0;
  logic [1:0] ram_crtl = 2'b00;
  logic [3:0] ram_data_out;
  logic       ram_valid;
  logic       ram_ready;
`ifdef RAM_PARITY_EN
  logic       par_inject = 1'b0;
  logic       ram_par_err;
`endif

  int checks = 0;
  int failures = 0;

  ram_responder #(.ADDR_W(4), .DATA_W(4), .CLEAR_ON_RESET(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_crtl     (ram_crtl),
`ifdef RAM_PARITY_EN
    .par_inject   (par_inject),
    .ram_par_err  (ram_par_err),
`endif
    .ram_data_out (ram_data_out),
    .ram_valid    (ram_valid),
    .ram_ready    (ram_ready)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it, inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ram_ready && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL %s: ready after %0d cycles, expected 16", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ram_crtl = 2'b00;
    repeat (3) step();
    checks++;
    if (ram_ready !== 1'b0 || ram_valid !== 1'b0 || ram_data_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h, expected 0 0 0",
               ram_ready, ram_valid, ram_data_out);
    end
    rst = 1'b0;
    wait_ready("clear_len");
  endtask

  task automatic test_clear_reads();
    for (int a = 0; a < 16; a++) begin
      ram_addr = 4'(a);
      ram_crtl = 2'b10;
      step();
      checks++;
      if (ram_data_out !== 4'h0 || ram_valid !== 1'b1) begin
        failures++;
        $display("FAIL clear_read[%0d]: data=%h valid=%b, expected 0 1", a, ram_data_out, ram_valid);
      end
    end
    ram_crtl = 2'b00;
    step();
    checks++;
    if (ram_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle_valid: valid=%b, expected 0", ram_valid);
    end
  endtask

  task automatic test_write_read();
    ram_addr = 4'h5; ram_data_in = 4'hA; ram_crtl = 2'b11;
    step();
    checks++;
    if (ram_valid !== 1'b0 || ram_data_out !== 4'h0) begin
      failures++;
      $display("FAIL write_no_valid: valid=%b data=%h, expected 0 0", ram_valid, ram_data_out);
    end
    ram_crtl = 2'b10;
    step();
    checks++;
    if (ram_valid !== 1'b1 || ram_data_out !== 4'hA) begin
      failures++;
      $display("FAIL read_after_write: valid=%b data=%h, expected 1 a", ram_valid, ram_data_out);
    end
    ram_crtl = 2'b00;
    step();
    checks++;
    if (ram_valid !== 1'b0 || ram_data_out !== 4'hA) begin
      failures++;
      $display("FAIL idle_hold: valid=%b data=%h, expected 0 a", ram_valid, ram_data_out);
    end
  endtask

  task automatic test_cs_low();
    ram_addr = 4'h3; ram_data_in = 4'h7; ram_crtl = 2'b01;
    step();
    checks++;
    if (ram_valid !== 1'b0 || ram_data_out !== 4'hA) begin
      failures++;
      $display("FAIL cs_low_hold: valid=%b data=%h, expected 0 a", ram_valid, ram_data_out);
    end
    ram_crtl = 2'b10;
    step();
    checks++;
    if (ram_valid !== 1'b1 || ram_data_out !== 4'h0) begin
      failures++;
      $display("FAIL cs_low_no_write: valid=%b data=%h, expected 1 0", ram_valid, ram_data_out);
    end
    ram_crtl = 2'b00;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] addrs [3];
    addrs[0] = 4'hF; addrs[1] = 4'h0; addrs[2] = 4'h1;
    for (int i = 0; i < 3; i++) begin
      ram_addr = addrs[i]; ram_data_in = 4'(i + 1); ram_crtl = 2'b11;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      ram_addr = addrs[i]; ram_crtl = 2'b10;
      step();
      checks++;
      if (ram_valid !== 1'b1 || ram_data_out !== 4'(i + 1)) begin
        failures++;
        $display("FAIL b2b_read[%0d]: valid=%b data=%h, expected 1 %0d", i, ram_valid, ram_data_out, i + 1);
      end
    end
    ram_crtl = 2'b00;
    step();
    checks++;
    if (ram_valid !== 1'b0 || ram_data_out !== 4'h3) begin
      failures++;
      $display("FAIL b2b_end: valid=%b data=%h, expected 0 3", ram_valid, ram_data_out);
    end
  endtask

  task automatic test_midclear_reset();
    ram_addr = 4'h2; ram_data_in = 4'hC; ram_crtl = 2'b11;
    step();
    ram_crtl = 2'b00;
    rst = 1'b1;
    step();
    checks++;
    if (ram_data_out !== 4'h0 || ram_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_clears_out: data=%h ready=%b, expected 0 0", ram_data_out, ram_ready);
    end
    rst = 1'b0;
    // Clear cycles 1..8; requests during cycles 5..8 must be ignored.
    for (int c = 1; c <= 8; c++) begin
      if (c >= 5) begin
        ram_addr = 4'h2; ram_data_in = 4'h9; ram_crtl = (c == 8) ? 2'b10 : 2'b11;
      end
      step();
      checks++;
      if (ram_ready !== 1'b0 || ram_valid !== 1'b0) begin
        failures++;
        $display("FAIL clear_ignore[%0d]: ready=%b valid=%b, expected 0 0", c, ram_ready, ram_valid);
      end
    end
    ram_crtl = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("reclear_len");
    ram_addr = 4'h2; ram_crtl = 2'b10;
    step();
    checks++;
    if (ram_valid !== 1'b1 || ram_data_out !== 4'h0) begin
      failures++;
      $display("FAIL clear_write_ignored: valid=%b data=%h, expected 1 0", ram_valid, ram_data_out);
    end
    ram_crtl = 2'b00;
    step();
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    ram_addr = 4'h9; ram_data_in = 4'h6; ram_crtl = 2'b11; par_inject = 1'b1;
    step();
    par_inject = 1'b0; ram_crtl = 2'b10;
    step();
    checks++;
    if (ram_data_out !== 4'h6 || ram_par_err !== 1'b1 || ram_valid !== 1'b1) begin
      failures++;
      $display("FAIL par_inject: data=%h err=%b valid=%b, expected 6 1 1", ram_data_out, ram_par_err, ram_valid);
    end
    ram_crtl = 2'b00;
    step();
    checks++;
    if (ram_par_err !== 1'b0) begin
      failures++;
      $display("FAIL par_pulse: err=%b, expected 0", ram_par_err);
    end
    ram_crtl = 2'b11;
    step();
    ram_crtl = 2'b10;
    step();
    checks++;
    if (ram_data_out !== 4'h6 || ram_par_err !== 1'b0) begin
      failures++;
      $display("FAIL par_clean: data=%h err=%b, expected 6 0", ram_data_out, ram_par_err);
    end
    ram_crtl = 2'b00;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_cs_low();
    test_back_to_back();
    test_midclear_reset();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
